// File: rtl/wrr_grant_scheduler_pkg.sv
// Shared types and limits for the weighted round-robin grant scheduler.
package wrr_sched_pkg;
  localparam int MAX_LANES = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    HOLD  = 2'd2
  } sched_state_e;
endpackage

// File: rtl/wrr_grant_scheduler_if.sv
// Requester-side handshake bundle: per-lane request/stall/flush in, grant/fire/starve out.
interface wrr_grant_scheduler_if #(
  parameter int NUM_REQ  = 2,
  parameter int WEIGHT_W = 3
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]          req;
  logic [NUM_REQ-1:0]          stall;
  logic [NUM_REQ-1:0]          flush;
  logic                        cfg_load;
  logic [NUM_REQ*WEIGHT_W-1:0] weight_cfg;
  logic [NUM_REQ-1:0]          grant;
  logic [IDX_W-1:0]            grant_idx;
  logic [NUM_REQ-1:0]          fire;
  logic [NUM_REQ-1:0]          starve;

  modport master (
    output req, stall, flush, cfg_load, weight_cfg,
    input  grant, grant_idx, fire, starve
  );

  modport slave (
    input  req, stall, flush, cfg_load, weight_cfg,
    output grant, grant_idx, fire, starve
  );
endinterface

// File: rtl/wrr_grant_scheduler_rr_pick.sv
// Combinational picker: lowest-index starving requester first, else rotate from ptr+1.
module rr_pick
  import wrr_sched_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         starve,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         win,
  output logic                       vld
);
  logic found;
  int   j;

  always_comb begin
    win   = '0;
    vld   = |req;
    found = 1'b0;
    j     = 0;
    if (|(req & starve)) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i] && starve[i]) begin
          win[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end else begin
      // k = NUM_REQ lands back on ptr, so the last-granted lane is searched last.
      for (int k = 1; k <= NUM_REQ; k++) begin
        j = (int'(ptr) + k) % NUM_REQ;
        if (!found && req[j]) begin
          win[j] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/wrr_grant_scheduler.sv
// Weighted round-robin grant scheduler: registered one-hot grant, per-lane credit
// weights, stall hold, flush release and starvation-forced service.
module wrr_grant_scheduler
  import wrr_sched_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int WEIGHT_W     = 3,
  parameter int STARVE_W     = 4,
  parameter int STARVE_LIMIT = 12
) (
  input logic             clk,
  input logic             reset,
  wrr_grant_scheduler_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [STARVE_W-1:0] CNT_MAX = '1;

  if (NUM_REQ < 2 || NUM_REQ > MAX_LANES) begin : g_param_chk
    $error("wrr_grant_scheduler: NUM_REQ out of range");
  end

  sched_state_e                      state;
  logic [NUM_REQ-1:0]                grant_q;
  logic [IDX_W-1:0]                  idx_q;
  logic [IDX_W-1:0]                  ptr_q;
  logic [WEIGHT_W-1:0]               credit_q;
  logic [NUM_REQ-1:0][WEIGHT_W-1:0]  weight_q;
  logic [NUM_REQ-1:0]                starve_q;

  logic [NUM_REQ-1:0]  req_eff;
  logic [NUM_REQ-1:0]  fire;
  logic [NUM_REQ-1:0]  win;
  logic                win_vld;
  logic [IDX_W-1:0]    win_idx;
  logic [WEIGHT_W-1:0] win_w;
  logic [WEIGHT_W-1:0] load_credit;
  logic                g_req, g_flush, g_fire, release_g;

  assign req_eff = bus.req & ~bus.flush;
  assign fire    = grant_q & bus.req & ~bus.stall & ~bus.flush;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (req_eff),
    .starve (starve_q),
    .ptr    (ptr_q),
    .win    (win),
    .vld    (win_vld)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (win[i]) win_idx = IDX_W'(i);
  end

  assign win_w       = weight_q[win_idx];
  assign load_credit = (win_w == '0) ? WEIGHT_W'(1) : win_w;

  assign g_req     = bus.req[idx_q];
  assign g_flush   = bus.flush[idx_q];
  assign g_fire    = fire[idx_q];
  assign release_g = g_flush || !g_req || (g_fire && credit_q == WEIGHT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      grant_q  <= '0;
      idx_q    <= '0;
      ptr_q    <= IDX_W'(NUM_REQ - 1);
      credit_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            grant_q  <= win;
            idx_q    <= win_idx;
            ptr_q    <= win_idx;
            credit_q <= load_credit;
            state    <= SERVE;
          end
        end
        SERVE, HOLD: begin
          // HOLD differs only in label: a frozen grant resumes the same release rules.
          if (release_g) begin
            if (win_vld) begin
              grant_q  <= win;
              idx_q    <= win_idx;
              ptr_q    <= win_idx;
              credit_q <= load_credit;
              state    <= SERVE;
            end else begin
              grant_q  <= '0;
              idx_q    <= '0;
              credit_q <= '0;
              state    <= IDLE;
            end
          end else if (g_fire) begin
            credit_q <= credit_q - 1'b1;
            state    <= SERVE;
          end else begin
            state    <= HOLD;
          end
        end
        default: begin
          grant_q  <= '0;
          idx_q    <= '0;
          credit_q <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // New weights only matter at the next credit load; the live credit is untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) weight_q[i] <= WEIGHT_W'(1);
    end else if (bus.cfg_load) begin
      weight_q <= bus.weight_cfg;
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    logic [STARVE_W-1:0] cnt_q, cnt_nxt;
    logic                st_q;

    always_comb begin
      cnt_nxt = cnt_q;
      if (!bus.req[i] || bus.flush[i] || grant_q[i]) cnt_nxt = '0;
      else if (cnt_q != CNT_MAX)                     cnt_nxt = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q <= '0;
        st_q  <= 1'b0;
      end else begin
        cnt_q <= cnt_nxt;
        st_q  <= (cnt_nxt >= STARVE_W'(STARVE_LIMIT));
      end
    end

    assign starve_q[i] = st_q;
  end

  assign bus.grant     = grant_q;
  assign bus.grant_idx = idx_q;
  assign bus.fire      = fire;
  assign bus.starve    = starve_q;
endmodule

// File: tb/tb_wrr_grant_scheduler.sv
// Directed bench for wrr_grant_scheduler: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them.
module tb_wrr_grant_scheduler;
  logic clk = 1'b0;
  logic reset;

  wrr_grant_scheduler_if #(.NUM_REQ(2), .WEIGHT_W(3)) bus ();

  wrr_grant_scheduler #(
    .NUM_REQ(2), .WEIGHT_W(3), .STARVE_W(4), .STARVE_LIMIT(12)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [1:0] grant;
    logic [1:0] fire;
    logic [1:0] starve;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic cmp(input string nm, input string fld, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s actual=%b required=%b", nm, fld, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge and record what that cycle must show.
  task automatic step(input string nm, input logic rst, input logic [1:0] r, st, fl,
                      input logic ld, input logic [5:0] wc,
                      input logic [1:0] eg, ef, es);
    exp_t e;
    @(posedge clk);
    #1;
    reset          = rst;
    bus.req        = r;
    bus.stall      = st;
    bus.flush      = fl;
    bus.cfg_load   = ld;
    bus.weight_cfg = wc;
    e.name   = nm;
    e.grant  = eg;
    e.fire   = ef;
    e.starve = es;
    q.push_back(e);
  endtask

  task automatic do_reset();
    step("reset", 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 6'd0, 2'b00, 2'b00, 2'b00);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp(e.name, "grant",     {6'd0, bus.grant},     {6'd0, e.grant});
        cmp(e.name, "grant_idx", {7'd0, bus.grant_idx}, {7'd0, e.grant[1]});
        cmp(e.name, "fire",      {6'd0, bus.fire},      {6'd0, e.fire});
        cmp(e.name, "starve",    {6'd0, bus.starve},    {6'd0, e.starve});
      end
    end
  end

  initial begin : stim
    reset          = 1'b1;
    bus.req        = '0;
    bus.stall      = '0;
    bus.flush      = '0;
    bus.cfg_load   = 1'b0;
    bus.weight_cfg = '0;

    // t1: single request, 1-cycle latency, release to idle when req drops
    do_reset();
    step("t1.c0", 0, 2'b01, 2'b00, 2'b00, 0, 6'd0, 2'b00, 2'b00, 2'b00);
    step("t1.c1", 0, 2'b01, 2'b00, 2'b00, 0, 6'd0, 2'b01, 2'b01, 2'b00);
    step("t1.c2", 0, 2'b00, 2'b00, 2'b00, 0, 6'd0, 2'b01, 2'b00, 2'b00);
    step("t1.c3", 0, 2'b00, 2'b00, 2'b00, 0, 6'd0, 2'b00, 2'b00, 2'b00);

    // t2: weights lane1=3 lane0=2, both requesting -> 01,01,10,10,10,01,01,10
    do_reset();
    step("t2.cfg", 0, 2'b00, 2'b00, 2'b00, 1, {3'd3, 3'd2}, 2'b00, 2'b00, 2'b00);
    step("t2.c1",  0, 2'b11, 2'b00, 2'b00, 0, 6'd0, 2'b00, 2'b00, 2'b00);
    step("t2.c2",  0, 2'b11, 2'b00, 2'b00, 0, 6'd0, 2'b01, 2'b01, 2'b00);
    step("t2.c3",  0, 2'b11, 2'b00, 2'b00, 0, 6'd0, 2'b01, 2'b01, 2'b00);
    step("t2.c4",  0, 2'b11, 2'b00, 2'b00, 0, 6'd0, 2'b10, 2'b10, 2'b00);
    step("t2.c5",  0, 2'b11, 2'b00, 2'b00, 0, 6'd0, 2'b10, 2'b10, 2'b00);
    step("t2.c6",  0, 2'b11, 2'b00, 2'b00, 0, 6'd0, 2'b10, 2'b10, 2'b00);
    step("t2.c7",  0, 2'b11, 2'b00, 2'b00, 0, 6'd0, 2'b01, 2'b01, 2'b00);
    step("t2.c8",  0, 2'b11, 2'b00, 2'b00, 0, 6'd0, 2'b01, 2'b01, 2'b00);
    step("t2.c9",  0, 2'b11, 2'b00, 2'b00, 0, 6'd0, 2'b10, 2'b10, 2'b00);

    // t3: lane0 stalled 5 cycles, credit frozen, then exactly 2 fires before lane1
    do_reset();
    step("t3.cfg", 0, 2'b00, 2'b00, 2'b00, 1, {3'd1, 3'd2}, 2'b00, 2'b00, 2'b00);
    step("t3.c1",  0, 2'b11, 2'b00, 2'b00, 0, 6'd0, 2'b00, 2'b00, 2'b00);
    for (int k = 0; k < 5; k++)
      step("t3.hold", 0, 2'b11, 2'b01, 2'b00, 0, 6'd0, 2'b01, 2'b00, 2'b00);
    step("t3.c7",  0, 2'b11, 2'b00, 2'b00, 0, 6'd0, 2'b01, 2'b01, 2'b00);
    step("t3.c8",  0, 2'b11, 2'b00, 2'b00, 0, 6'd0, 2'b01, 2'b01, 2'b00);
    step("t3.c9",  0, 2'b10, 2'b00, 2'b00, 0, 6'd0, 2'b10, 2'b10, 2'b00);

    // t4: flush on granted lane1 kills its fire and hands over to lane0
    do_reset();
    step("t4.c0", 0, 2'b10, 2'b00, 2'b00, 0, 6'd0, 2'b00, 2'b00, 2'b00);
    step("t4.c1", 0, 2'b11, 2'b00, 2'b10, 0, 6'd0, 2'b10, 2'b00, 2'b00);
    step("t4.c2", 0, 2'b01, 2'b00, 2'b00, 0, 6'd0, 2'b01, 2'b01, 2'b00);

    // t5: lane0 weight 7 held in HOLD 12 cycles -> lane1 starves, then served
    do_reset();
    step("t5.cfg", 0, 2'b00, 2'b00, 2'b00, 1, {3'd1, 3'd7}, 2'b00, 2'b00, 2'b00);
    step("t5.c1",  0, 2'b01, 2'b00, 2'b00, 0, 6'd0, 2'b00, 2'b00, 2'b00);
    for (int k = 0; k < 12; k++)
      step("t5.hold", 0, 2'b11, 2'b01, 2'b00, 0, 6'd0, 2'b01, 2'b00, 2'b00);
    step("t5.c14", 0, 2'b10, 2'b00, 2'b00, 0, 6'd0, 2'b01, 2'b00, 2'b10);
    step("t5.c15", 0, 2'b10, 2'b00, 2'b00, 0, 6'd0, 2'b10, 2'b10, 2'b10);
    step("t5.c16", 0, 2'b00, 2'b00, 2'b00, 0, 6'd0, 2'b10, 2'b00, 2'b00);

    // t6: async reset mid-grant, then first search starts at lane0
    do_reset();
    step("t6.c0",  0, 2'b10, 2'b00, 2'b00, 0, 6'd0, 2'b00, 2'b00, 2'b00);
    step("t6.c1",  0, 2'b10, 2'b00, 2'b00, 0, 6'd0, 2'b10, 2'b10, 2'b00);
    step("t6.rst", 1, 2'b10, 2'b00, 2'b00, 0, 6'd0, 2'b00, 2'b00, 2'b00);
    step("t6.c3",  0, 2'b11, 2'b00, 2'b00, 0, 6'd0, 2'b00, 2'b00, 2'b00);
    step("t6.c4",  0, 2'b11, 2'b00, 2'b00, 0, 6'd0, 2'b01, 2'b01, 2'b00);

    // t7: weight 0 behaves as 1 -> strict alternation
    do_reset();
    step("t7.cfg", 0, 2'b00, 2'b00, 2'b00, 1, 6'd0, 2'b00, 2'b00, 2'b00);
    step("t7.c1",  0, 2'b11, 2'b00, 2'b00, 0, 6'd0, 2'b00, 2'b00, 2'b00);
    step("t7.c2",  0, 2'b11, 2'b00, 2'b00, 0, 6'd0, 2'b01, 2'b01, 2'b00);
    step("t7.c3",  0, 2'b11, 2'b00, 2'b00, 0, 6'd0, 2'b10, 2'b10, 2'b00);
    step("t7.c4",  0, 2'b11, 2'b00, 2'b00, 0, 6'd0, 2'b01, 2'b01, 2'b00);

    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
